slave_in: RTL and testbench
===========================

// Module: slave_in
// PURPOSE
// Slave-side serial receiver on the system bus, directly downstream of the master transmit stage.
// Detects its slave ID on the select line, then deserialises address, burst count and write data
// (all LSB-first), and drives parallel write/read strobes into the slave's local memory.
// Read data return is handled by the separate slave transmit stage, which is triggered by mem_re.
// PARAMETERS
// SLAVE_LEN  2    width of slave ID on select line
// ADDR_LEN   12   address bits
// DATA_LEN   8    data bits per beat
// BURST_LEN  12   burst-count bits
// SLAVE_ID   0    this slave's ID (SLAVE_LEN bits)
// TIMEOUT    15   max consecutive idle (master_valid=0) cycles inside ADDR/WDATA before abort
// PORTS
// clk              in   1          bus clock, rising edge
// reset            in   1          asynchronous, active-high
// approval_grant   in   1          arbiter grant; bus owned by a master while 1
// rx_slave_select  in   1          serial slave-select line
// master_valid     in   1          qualifies rx_address / rx_burst_number / rx_data bits
// rx_address       in   1          serial address
// rx_burst_number  in   1          serial burst count (one leading pad bit, then BURST_LEN bits)
// rx_data          in   1          serial write data
// write_en         in   1          master write qualifier
// read_en          in   1          master read qualifier
// slave_ready      out  1          slave selected and accepting bits
// mem_addr         out  ADDR_LEN   local address for current beat
// mem_wdata        out  DATA_LEN   assembled write data
// mem_we           out  1          1-cycle write strobe
// mem_re           out  1          1-cycle read strobe (one per beat)
// xfer_done        out  1          1-cycle pulse at normal end of transaction
// rx_error         out  1          1-cycle pulse on abort (timeout / grant loss)
// BEHAVIOUR
// - Reset (async): state=IDLE, all outputs 0, all counters/shift registers 0. Reset mid-transfer
//   discards the partial beat; no strobe is issued.
// - Any state != IDLE: approval_grant=0 -> IDLE next cycle, rx_error pulse, no mem_we/mem_re for
//   the incomplete beat (completed beats already written stand).
// - IDLE: approval_grant=1 and rx_slave_select=1 (start bit) -> SELECT, bit counter=0.
// - SELECT: samples SLAVE_LEN bits, one per cycle, LSB first, then one stop cycle (ignored).
//   At stop cycle: ID==SLAVE_ID -> ADDR, slave_ready<=1; else -> IDLE silently (no error).
// - ADDR: on each edge with master_valid=1, shift rx_address (ADDR_LEN samples) and
//   rx_burst_number (first sample is pad, dropped; then BURST_LEN samples) independently.
//   Leaves when both counters complete: beats = (burst==0) ? 1 : burst; beat index=0.
//   write_en=1 -> WDATA; read_en=1 -> RDATA; both or neither -> IDLE with rx_error.
// - WDATA: each master_valid=1 edge shifts one rx_data bit; after DATA_LEN bits, next cycle:
//   mem_wdata=assembled word, mem_addr=base+index, mem_we=1 for exactly 1 cycle.
//   Bits of the next beat may arrive on the strobe cycle and are accepted (no bubble required).
//   After last beat's strobe: xfer_done pulse, slave_ready<=0, -> IDLE.
// - RDATA: mem_re=1 on consecutive cycles, one per beat, mem_addr=base+index; after last
//   beat xfer_done pulse, slave_ready<=0, -> IDLE.
// - Address arithmetic: base+index modulo 2^ADDR_LEN (wraps, no error). Burst count is
//   unsigned BURST_LEN bits; max 2^BURST_LEN-1 beats.
// - Timeout: idle counter increments on master_valid=0 in ADDR/WDATA, clears on master_valid=1;
//   reaching TIMEOUT -> IDLE, rx_error pulse, slave_ready<=0.
// - mem_we, mem_re, xfer_done, rx_error never asserted in the same cycle except
//   xfer_done together with the final mem_we/mem_re? No: xfer_done is the cycle after it.
// - Latency: last data bit sampled at edge N -> mem_we high during cycle N+1; xfer_done N+2.
// TESTING
// 1 Select ID=SLAVE_ID, addr=0x0A5, burst=0, write data=0x3C -> single mem_we, mem_addr=0x0A5,
//   mem_wdata=0x3C, xfer_done next cycle, slave_ready back to 0.
// 2 Select ID!=SLAVE_ID then full frame -> slave_ready stays 0, no strobes, no rx_error.
// 3 Write burst=3 at addr=0xFFE, data 0x11,0x22,0x33 back-to-back -> mem_we at 0xFFE,0xFFF,0x000.
// 4 Read burst=4 at addr=0x010 -> mem_re 4 consecutive cycles, addr 0x010..0x013, then xfer_done.
// 5 Drop approval_grant after 5 data bits -> rx_error pulse, no mem_we, state IDLE; same for
//   reset asserted mid-beat (outputs 0 immediately).
// 6 Hold master_valid=0 for TIMEOUT cycles in WDATA -> rx_error, IDLE; TIMEOUT-1 gap -> no abort.

Source files
------------

// File: rtl/slave_in_if.sv
// Serial bus bundle between the master transmit stage and the slave receive stage,
// plus the parallel local-memory strobes the receiver produces.
interface slave_in_if #(
  parameter int unsigned ADDR_LEN = 12,
  parameter int unsigned DATA_LEN = 8
);
  logic                approval_grant;
  logic                rx_slave_select;
  logic                master_valid;
  logic                rx_address;
  logic                rx_burst_number;
  logic                rx_data;
  logic                write_en;
  logic                read_en;
  logic                slave_ready;
  logic [ADDR_LEN-1:0] mem_addr;
  logic [DATA_LEN-1:0] mem_wdata;
  logic                mem_we;
  logic                mem_re;
  logic                xfer_done;
  logic                rx_error;

  modport slave (
    input  approval_grant, rx_slave_select, master_valid, rx_address, rx_burst_number,
           rx_data, write_en, read_en,
    output slave_ready, mem_addr, mem_wdata, mem_we, mem_re, xfer_done, rx_error
  );

  modport master (
    output approval_grant, rx_slave_select, master_valid, rx_address, rx_burst_number,
           rx_data, write_en, read_en,
    input  slave_ready, mem_addr, mem_wdata, mem_we, mem_re, xfer_done, rx_error
  );
endinterface

// File: rtl/slave_in.sv
// Slave-side serial receiver: matches the slave ID, deserialises address/burst/write data
// (LSB first) and issues one-cycle write/read strobes into local memory.
module slave_in #(
  parameter int unsigned SLAVE_LEN = 2,
  parameter int unsigned ADDR_LEN  = 12,
  parameter int unsigned DATA_LEN  = 8,
  parameter int unsigned BURST_LEN = 12,
  parameter int unsigned SLAVE_ID  = 0,
  parameter int unsigned TIMEOUT   = 15
) (
  input logic       clk,
  input logic       reset,
  slave_in_if.slave bus
);

  localparam int unsigned CntW =
    $clog2(SLAVE_LEN + ADDR_LEN + BURST_LEN + DATA_LEN + TIMEOUT + 2);
  localparam logic [CntW-1:0] SelDone   = CntW'(SLAVE_LEN);
  localparam logic [CntW-1:0] AddrDone  = CntW'(ADDR_LEN);
  localparam logic [CntW-1:0] BurstDone = CntW'(BURST_LEN + 1);
  localparam logic [CntW-1:0] DataDone  = CntW'(DATA_LEN);
  localparam logic [CntW-1:0] IdleLimit = CntW'(TIMEOUT);

  typedef enum logic [2:0] {StIdle, StSelect, StAddr, StWdata, StRdata, StDone} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      sel_cnt_q, sel_cnt_d;
  logic [CntW-1:0]      addr_cnt_q, addr_cnt_d;
  logic [CntW-1:0]      burst_cnt_q, burst_cnt_d;
  logic [CntW-1:0]      data_cnt_q, data_cnt_d;
  logic [CntW-1:0]      idle_cnt_q, idle_cnt_d;
  logic [SLAVE_LEN-1:0] id_q, id_d;
  logic [ADDR_LEN-1:0]  addr_sr_q, addr_sr_d;
  logic [BURST_LEN-1:0] burst_sr_q, burst_sr_d;
  logic [DATA_LEN-1:0]  data_sr_q, data_sr_d;
  logic [BURST_LEN-1:0] beats_q, beats_d;
  logic [BURST_LEN-1:0] index_q, index_d;
  logic                 slave_ready_q, slave_ready_d;
  logic [ADDR_LEN-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_LEN-1:0]  mem_wdata_q, mem_wdata_d;
  logic                 mem_we_q, mem_we_d;
  logic                 mem_re_q, mem_re_d;
  logic                 xfer_done_q, xfer_done_d;
  logic                 rx_error_q, rx_error_d;

  always_comb begin
    state_d       = state_q;
    sel_cnt_d     = sel_cnt_q;
    addr_cnt_d    = addr_cnt_q;
    burst_cnt_d   = burst_cnt_q;
    data_cnt_d    = data_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    id_d          = id_q;
    addr_sr_d     = addr_sr_q;
    burst_sr_d    = burst_sr_q;
    data_sr_d     = data_sr_q;
    beats_d       = beats_q;
    index_d       = index_q;
    slave_ready_d = slave_ready_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_we_d      = 1'b0;
    mem_re_d      = 1'b0;
    xfer_done_d   = 1'b0;
    rx_error_d    = 1'b0;

    // Losing the bus aborts everything in flight; the partial beat is dropped.
    if (state_q != StIdle && !bus.approval_grant) begin
      state_d       = StIdle;
      rx_error_d    = 1'b1;
      slave_ready_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.approval_grant && bus.rx_slave_select) begin
            state_d   = StSelect;
            sel_cnt_d = '0;
          end
        end

        StSelect: begin
          if (sel_cnt_q != SelDone) begin
            id_d      = SLAVE_LEN'({bus.rx_slave_select, id_q} >> 1);
            sel_cnt_d = sel_cnt_q + CntW'(1);
          end else if (id_q == SLAVE_LEN'(SLAVE_ID)) begin
            state_d       = StAddr;
            slave_ready_d = 1'b1;
            addr_cnt_d    = '0;
            burst_cnt_d   = '0;
            idle_cnt_d    = '0;
          end else begin
            state_d = StIdle;
          end
        end

        StAddr: begin
          if (bus.master_valid) begin
            idle_cnt_d = '0;
            if (addr_cnt_q != AddrDone) begin
              addr_sr_d  = ADDR_LEN'({bus.rx_address, addr_sr_q} >> 1);
              addr_cnt_d = addr_cnt_q + CntW'(1);
            end
            // The first burst sample is a pad bit and is discarded.
            if (burst_cnt_q != BurstDone) begin
              if (burst_cnt_q != '0) begin
                burst_sr_d = BURST_LEN'({bus.rx_burst_number, burst_sr_q} >> 1);
              end
              burst_cnt_d = burst_cnt_q + CntW'(1);
            end
            if (addr_cnt_d == AddrDone && burst_cnt_d == BurstDone) begin
              beats_d    = (burst_sr_d == '0) ? BURST_LEN'(1) : burst_sr_d;
              index_d    = '0;
              data_cnt_d = '0;
              if (bus.write_en && !bus.read_en) begin
                state_d = StWdata;
              end else if (bus.read_en && !bus.write_en) begin
                state_d = StRdata;
              end else begin
                state_d       = StIdle;
                rx_error_d    = 1'b1;
                slave_ready_d = 1'b0;
              end
            end
          end else begin
            idle_cnt_d = idle_cnt_q + CntW'(1);
            if (idle_cnt_d == IdleLimit) begin
              state_d       = StIdle;
              rx_error_d    = 1'b1;
              slave_ready_d = 1'b0;
            end
          end
        end

        StWdata: begin
          if (bus.master_valid) begin
            idle_cnt_d = '0;
            data_sr_d  = DATA_LEN'({bus.rx_data, data_sr_q} >> 1);
            data_cnt_d = data_cnt_q + CntW'(1);
            if (data_cnt_d == DataDone) begin
              mem_we_d    = 1'b1;
              mem_wdata_d = data_sr_d;
              mem_addr_d  = addr_sr_q + ADDR_LEN'(index_q);
              data_cnt_d  = '0;
              index_d     = index_q + BURST_LEN'(1);
              if (index_d == beats_q) begin
                state_d = StDone;
              end
            end
          end else begin
            idle_cnt_d = idle_cnt_q + CntW'(1);
            if (idle_cnt_d == IdleLimit) begin
              state_d       = StIdle;
              rx_error_d    = 1'b1;
              slave_ready_d = 1'b0;
            end
          end
        end

        StRdata: begin
          if (index_q != beats_q) begin
            mem_re_d   = 1'b1;
            mem_addr_d = addr_sr_q + ADDR_LEN'(index_q);
            index_d    = index_q + BURST_LEN'(1);
          end else begin
            state_d       = StIdle;
            xfer_done_d   = 1'b1;
            slave_ready_d = 1'b0;
          end
        end

        StDone: begin
          state_d       = StIdle;
          xfer_done_d   = 1'b1;
          slave_ready_d = 1'b0;
        end

        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      sel_cnt_q     <= '0;
      addr_cnt_q    <= '0;
      burst_cnt_q   <= '0;
      data_cnt_q    <= '0;
      idle_cnt_q    <= '0;
      id_q          <= '0;
      addr_sr_q     <= '0;
      burst_sr_q    <= '0;
      data_sr_q     <= '0;
      beats_q       <= '0;
      index_q       <= '0;
      slave_ready_q <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_we_q      <= 1'b0;
      mem_re_q      <= 1'b0;
      xfer_done_q   <= 1'b0;
      rx_error_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_cnt_q     <= sel_cnt_d;
      addr_cnt_q    <= addr_cnt_d;
      burst_cnt_q   <= burst_cnt_d;
      data_cnt_q    <= data_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      id_q          <= id_d;
      addr_sr_q     <= addr_sr_d;
      burst_sr_q    <= burst_sr_d;
      data_sr_q     <= data_sr_d;
      beats_q       <= beats_d;
      index_q       <= index_d;
      slave_ready_q <= slave_ready_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_we_q      <= mem_we_d;
      mem_re_q      <= mem_re_d;
      xfer_done_q   <= xfer_done_d;
      rx_error_q    <= rx_error_d;
    end
  end

  assign bus.slave_ready = slave_ready_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_re      = mem_re_q;
  assign bus.xfer_done   = xfer_done_q;
  assign bus.rx_error    = rx_error_q;

endmodule

// File: tb/tb_slave_in.sv
// Directed bench for slave_in: serial frames in, memory strobes checked against a scoreboard.
module tb_slave_in;

  logic clk = 1'b0;
  logic reset;

  slave_in_if #(.ADDR_LEN(12), .DATA_LEN(8)) bus ();

  slave_in #(
    .SLAVE_LEN(2), .ADDR_LEN(12), .DATA_LEN(8), .BURST_LEN(12), .SLAVE_ID(0), .TIMEOUT(15)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_wr;
    logic [11:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t sb[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   done_cnt  = 0;
  int   err_cnt   = 0;
  int   ready_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.mem_we || bus.mem_re) begin
      check("strobe_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("strobe_kind", 32'(bus.mem_we), 32'(e.is_wr));
        check("strobe_addr", 32'(bus.mem_addr), 32'(e.addr));
        if (e.is_wr) check("strobe_wdata", 32'(bus.mem_wdata), 32'(e.data));
      end
    end
    if (bus.mem_we || bus.mem_re || bus.xfer_done || bus.rx_error)
      check("pulse_exclusive",
            32'($countones({bus.mem_we, bus.mem_re, bus.xfer_done, bus.rx_error})), 32'd1);
    if (bus.xfer_done) done_cnt++;
    if (bus.rx_error) err_cnt++;
    if (bus.slave_ready) ready_cnt++;
  end

  task automatic send_frame(input logic [1:0] id, input logic [11:0] addr,
                            input logic [11:0] burst, input logic we, input logic re);
    @(negedge clk);
    bus.rx_slave_select = 1'b1;
    bus.write_en        = we;
    bus.read_en         = re;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.rx_slave_select = id[i];
    end
    @(negedge clk);
    bus.rx_slave_select = 1'b0;
    for (int i = 0; i < 13; i++) begin
      int ai = (i < 12) ? i : 0;
      int bi = (i == 0) ? 0 : i - 1;
      @(negedge clk);
      bus.master_valid    = 1'b1;
      bus.rx_address      = (i < 12) ? addr[ai] : 1'b0;
      bus.rx_burst_number = (i == 0) ? 1'b0 : burst[bi];
    end
  endtask

  task automatic send_bits(input logic [7:0] data, input int lo, input int n);
    for (int i = lo; i < lo + n; i++) begin
      @(negedge clk);
      bus.master_valid = 1'b1;
      bus.rx_data      = data[i];
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.master_valid = 1'b0;
    end
  endtask

  initial begin
    int   d0, e0, r0;
    logic got;
    reset               = 1'b1;
    bus.approval_grant  = 1'b1;
    bus.rx_slave_select = 1'b0;
    bus.master_valid    = 1'b0;
    bus.rx_address      = 1'b0;
    bus.rx_burst_number = 1'b0;
    bus.rx_data         = 1'b0;
    bus.write_en        = 1'b0;
    bus.read_en         = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'({bus.slave_ready, bus.mem_we, bus.mem_re, bus.xfer_done,
                                bus.rx_error, bus.mem_addr, bus.mem_wdata}), 32'd0);
    reset = 1'b0;
    idle_cycles(2);

    // Single write beat.
    d0 = done_cnt;
    sb.push_back('{is_wr: 1'b1, addr: 12'h0A5, data: 8'h3C});
    send_frame(2'd0, 12'h0A5, 12'd0, 1'b1, 1'b0);
    check("t1_ready", 32'(bus.slave_ready), 32'd1);
    send_bits(8'h3C, 0, 8);
    idle_cycles(1);
    check("t1_we_latency", 32'(bus.mem_we), 32'd1);
    idle_cycles(1);
    check("t1_done_latency", 32'(bus.xfer_done), 32'd1);
    check("t1_ready_cleared", 32'(bus.slave_ready), 32'd0);
    idle_cycles(2);
    check("t1_done_count", 32'(done_cnt - d0), 32'd1);

    // Foreign slave ID: completely silent.
    d0 = done_cnt; e0 = err_cnt; r0 = ready_cnt;
    send_frame(2'd1, 12'h0A5, 12'd0, 1'b1, 1'b0);
    send_bits(8'h3C, 0, 8);
    idle_cycles(4);
    check("t2_ready_never", 32'(ready_cnt - r0), 32'd0);
    check("t2_no_error", 32'(err_cnt - e0), 32'd0);
    check("t2_no_done", 32'(done_cnt - d0), 32'd0);

    // Write burst of 3 across the address wrap, beats back-to-back.
    d0 = done_cnt;
    sb.push_back('{is_wr: 1'b1, addr: 12'hFFE, data: 8'h11});
    sb.push_back('{is_wr: 1'b1, addr: 12'hFFF, data: 8'h22});
    sb.push_back('{is_wr: 1'b1, addr: 12'h000, data: 8'h33});
    send_frame(2'd0, 12'hFFE, 12'd3, 1'b1, 1'b0);
    send_bits(8'h11, 0, 8);
    send_bits(8'h22, 0, 8);
    send_bits(8'h33, 0, 8);
    idle_cycles(4);
    check("t3_done_count", 32'(done_cnt - d0), 32'd1);
    check("t3_sb_drained", 32'(sb.size()), 32'd0);

    // Read burst of 4: consecutive mem_re, then xfer_done.
    for (int i = 0; i < 4; i++) sb.push_back('{is_wr: 1'b0, addr: 12'h010 + 12'(i), data: 8'h00});
    send_frame(2'd0, 12'h010, 12'd4, 1'b0, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge clk);
      bus.master_valid = 1'b0;
      got = bus.mem_re;
    end
    check("t4_re_start", 32'(got), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_re_consecutive", 32'(bus.mem_re), 32'd1);
    end
    @(negedge clk);
    check("t4_done", 32'(bus.xfer_done), 32'd1);
    idle_cycles(2);
    check("t4_sb_drained", 32'(sb.size()), 32'd0);

    // Grant loss mid-beat.
    e0 = err_cnt;
    send_frame(2'd0, 12'h100, 12'd0, 1'b1, 1'b0);
    send_bits(8'h5A, 0, 5);
    @(negedge clk);
    bus.approval_grant = 1'b0;
    bus.master_valid   = 1'b0;
    @(negedge clk);
    check("t5_grant_error", 32'(bus.rx_error), 32'd1);
    check("t5_grant_ready", 32'(bus.slave_ready), 32'd0);
    bus.approval_grant = 1'b1;
    idle_cycles(4);
    check("t5_err_count", 32'(err_cnt - e0), 32'd1);

    // Reset mid-beat clears outputs at once.
    send_frame(2'd0, 12'h200, 12'd0, 1'b1, 1'b0);
    send_bits(8'hFF, 0, 3);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t5_reset_outputs", 32'({bus.slave_ready, bus.mem_we, bus.mem_re, bus.xfer_done,
                                   bus.rx_error, bus.mem_addr, bus.mem_wdata}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle_cycles(4);

    // Timeout: TIMEOUT idle cycles abort.
    e0 = err_cnt;
    send_frame(2'd0, 12'h300, 12'd0, 1'b1, 1'b0);
    send_bits(8'h0F, 0, 4);
    idle_cycles(15);
    @(negedge clk);
    check("t6_timeout_error", 32'(bus.rx_error), 32'd1);
    idle_cycles(2);
    check("t6_timeout_ready", 32'(bus.slave_ready), 32'd0);
    check("t6_err_count", 32'(err_cnt - e0), 32'd1);

    // TIMEOUT-1 gap is tolerated.
    d0 = done_cnt; e0 = err_cnt;
    sb.push_back('{is_wr: 1'b1, addr: 12'h301, data: 8'hA5});
    send_frame(2'd0, 12'h301, 12'd0, 1'b1, 1'b0);
    send_bits(8'hA5, 0, 4);
    idle_cycles(14);
    send_bits(8'hA5, 4, 4);
    idle_cycles(4);
    check("t6_gap_no_error", 32'(err_cnt - e0), 32'd0);
    check("t6_gap_done", 32'(done_cnt - d0), 32'd1);

    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
